// File: rtl/usb_ep_pkg.sv
// Shared types and constants for the bulk endpoint router.
package usb_ep_pkg;

    localparam int USB_MAX_PKT_HS = 512;
    localparam int USB_MAX_PKT_FS = 64;
    localparam int EP_NUM_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IN    = 2'd1,
        ST_OUT   = 2'd2,
        ST_FLUSH = 2'd3
    } ep_state_e;

    // Endpoint maps to a channel only when the device is configured and ep is 1..num_eps.
    function automatic logic ep_hit(input logic cfg,
                                    input logic [EP_NUM_W-1:0] ep,
                                    input logic [EP_NUM_W-1:0] num_eps);
        return cfg && (ep != {EP_NUM_W{1'b0}}) && (ep <= num_eps);
    endfunction

endpackage

// File: rtl/usb_bulk_ep_mux_if.sv
// Transaction-layer side of the bulk endpoint router: transfer control,
// IN stream towards the host and OUT payload from the host.
interface usb_bulk_ep_mux_if;
    import usb_ep_pkg::*;

    logic [EP_NUM_W-1:0] blk_xfer_endpoint_i;
    logic                blk_in_xfer_i;
    logic                blk_out_xfer_i;
    logic                bid_has_data_o;
    logic                bid_tvalid_o;
    logic                bid_tready_i;
    logic                bid_tlast_o;
    logic [7:0]          bid_tdata_o;
    logic                blk_out_ready_o;
    logic                blk_out_tvalid_i;
    logic [7:0]          blk_out_tdata_i;

    modport master (
        output blk_xfer_endpoint_i, blk_in_xfer_i, blk_out_xfer_i,
        output bid_tready_i, blk_out_tvalid_i, blk_out_tdata_i,
        input  bid_has_data_o, bid_tvalid_o, bid_tlast_o, bid_tdata_o,
        input  blk_out_ready_o
    );

    modport slave (
        input  blk_xfer_endpoint_i, blk_in_xfer_i, blk_out_xfer_i,
        input  bid_tready_i, blk_out_tvalid_i, blk_out_tdata_i,
        output bid_has_data_o, bid_tvalid_o, bid_tlast_o, bid_tdata_o,
        output blk_out_ready_o
    );

endinterface

// File: rtl/usb_out_hold.sv
// One-byte OUT holding register: each byte is released when the next one
// arrives, the last one is released with tlast during the flush cycle.
module usb_out_hold (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       flush,
    output logic       beat_valid,
    output logic       beat_last,
    output logic [7:0] beat_data
);

    logic       hold_v_r;
    logic [7:0] hold_d_r;

    // Capture incoming bytes; drop the valid flag at transfer start or after flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_v_r <= 1'b0;
            hold_d_r <= 8'h00;
        end else if (clear) begin
            hold_v_r <= 1'b0;
        end else if (wr) begin
            hold_v_r <= 1'b1;
            hold_d_r <= din;
        end else if (flush) begin
            hold_v_r <= 1'b0;
        end
    end

    // A held byte leaves when displaced by a new byte or when flushed as the last one.
    always_comb begin
        beat_valid = hold_v_r & (wr | flush);
        beat_last  = hold_v_r & flush;
        beat_data  = hold_d_r;
    end

endmodule

// File: rtl/usb_bulk_ep_mux.sv
// Bulk endpoint router: one transaction-layer bulk path to NUM_EPS channels.
// IN packets are split at MAX_PACKET bytes; OUT packets get a regenerated tlast.
// Optional per-channel packet counters are built when USB_EP_STATS_EN is defined.
module usb_bulk_ep_mux
    import usb_ep_pkg::*;
#(
    parameter int NUM_EPS    = 2,
    parameter int MAX_PACKET = USB_MAX_PKT_HS,
    parameter int CW         = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   configured_i,
    usb_bulk_ep_mux_if.slave       tl,
    input  logic [NUM_EPS-1:0]     in_has_data_i,
    input  logic [NUM_EPS-1:0]     in_tvalid_i,
    output logic [NUM_EPS-1:0]     in_tready_o,
    input  logic [NUM_EPS-1:0]     in_tlast_i,
    input  logic [8*NUM_EPS-1:0]   in_tdata_i,
    input  logic [NUM_EPS-1:0]     out_ready_i,
    output logic [NUM_EPS-1:0]     out_tvalid_o,
    output logic [NUM_EPS-1:0]     out_tlast_o,
    output logic [8*NUM_EPS-1:0]   out_tdata_o
`ifdef USB_EP_STATS_EN
    ,
    output logic [16*NUM_EPS-1:0]  ep_pkt_count_o
`endif
);

    ep_state_e           state_r, state_nxt_s;
    logic [EP_NUM_W-1:0] sel_r, ep_s, adv_ch_s, path_ch_s;
    logic                hit_s, hit_q_r, in_act_s, in_beat_s, tlast_ch_s;
    logic [CW-1:0]       cnt_r;
    logic                bid_has_data_s, blk_out_ready_s, bid_tvalid_s, bid_tlast_s;
    logic [7:0]          bid_tdata_s;
    logic                hold_clear_s, hold_wr_s, hold_flush_s;
    logic                beat_v_s, beat_last_s;
    logic [7:0]          beat_data_s;

    // Live endpoint in IDLE, latched endpoint for the rest of the transaction.
    always_comb begin
        ep_s      = (state_r == ST_IDLE) ? tl.blk_xfer_endpoint_i : sel_r;
        hit_s     = ep_hit(configured_i, ep_s, EP_NUM_W'(NUM_EPS));
        adv_ch_s  = ep_s - EP_NUM_W'(1);
        path_ch_s = sel_r - EP_NUM_W'(1);
    end

    // Advertise data/space of the addressed channel, nothing when unmapped.
    always_comb begin
        bid_has_data_s  = 1'b0;
        blk_out_ready_s = 1'b0;
        for (int c = 0; c < NUM_EPS; c++) begin
            bid_has_data_s  = bid_has_data_s  | (hit_s & (adv_ch_s == EP_NUM_W'(c)) & in_has_data_i[c]);
            blk_out_ready_s = blk_out_ready_s | (hit_s & (adv_ch_s == EP_NUM_W'(c)) & out_ready_i[c]);
        end
    end

    // Transaction state: IN has priority over OUT; OUT always passes through FLUSH.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tl.blk_in_xfer_i)       state_nxt_s = ST_IN;
                else if (tl.blk_out_xfer_i) state_nxt_s = ST_OUT;
                else                        state_nxt_s = ST_IDLE;
            end
            ST_IN: begin
                if (!tl.blk_in_xfer_i) state_nxt_s = ST_IDLE;
                else                   state_nxt_s = ST_IN;
            end
            ST_OUT: begin
                if (!tl.blk_out_xfer_i) state_nxt_s = ST_FLUSH;
                else                    state_nxt_s = ST_OUT;
            end
            ST_FLUSH: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; endpoint and hit are latched once at transaction start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            sel_r   <= {EP_NUM_W{1'b0}};
            hit_q_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_IDLE && state_nxt_s != ST_IDLE) begin
                sel_r   <= ep_s;
                hit_q_r <= hit_s;
                cnt_r   <= {CW{1'b0}};
            end else if (in_beat_s) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Zero-latency IN mux; tlast is forced on the last byte a packet may carry.
    always_comb begin
        in_act_s     = (state_r == ST_IN) & hit_q_r & ~reset;
        bid_tvalid_s = 1'b0;
        bid_tdata_s  = 8'h00;
        tlast_ch_s   = 1'b0;
        in_tready_o  = {NUM_EPS{1'b0}};
        for (int c = 0; c < NUM_EPS; c++) begin
            bid_tvalid_s   = bid_tvalid_s | (in_act_s & (path_ch_s == EP_NUM_W'(c)) & in_tvalid_i[c]);
            tlast_ch_s     = tlast_ch_s   | (in_act_s & (path_ch_s == EP_NUM_W'(c)) & in_tlast_i[c]);
            bid_tdata_s    = bid_tdata_s  | ({8{in_act_s & (path_ch_s == EP_NUM_W'(c))}} & in_tdata_i[8*c +: 8]);
            in_tready_o[c] = in_act_s & (path_ch_s == EP_NUM_W'(c)) & tl.bid_tready_i;
        end
        bid_tlast_s = in_act_s & (tlast_ch_s | (cnt_r == CW'(MAX_PACKET - 1)));
        in_beat_s   = bid_tvalid_s & tl.bid_tready_i;
    end

    assign tl.bid_has_data_o  = ~reset & bid_has_data_s;
    assign tl.blk_out_ready_o = ~reset & blk_out_ready_s;
    assign tl.bid_tvalid_o    = bid_tvalid_s;
    assign tl.bid_tlast_o     = bid_tlast_s;
    assign tl.bid_tdata_o     = bid_tdata_s;

    // OUT holding-register controls; bytes without a mapped endpoint never enter.
    always_comb begin
        hold_clear_s = (state_r == ST_IDLE) & (state_nxt_s == ST_OUT);
        hold_wr_s    = (state_r == ST_OUT) & hit_q_r & tl.blk_out_tvalid_i;
        hold_flush_s = (state_r == ST_FLUSH) & hit_q_r;
    end

    usb_out_hold u_out_hold (
        .clock      (clock),
        .reset      (reset),
        .clear      (hold_clear_s),
        .wr         (hold_wr_s),
        .din        (tl.blk_out_tdata_i),
        .flush      (hold_flush_s),
        .beat_valid (beat_v_s),
        .beat_last  (beat_last_s),
        .beat_data  (beat_data_s)
    );

    // Route the released OUT byte to the latched channel only.
    always_comb begin
        out_tvalid_o = {NUM_EPS{1'b0}};
        out_tlast_o  = {NUM_EPS{1'b0}};
        out_tdata_o  = {(8*NUM_EPS){1'b0}};
        for (int c = 0; c < NUM_EPS; c++) begin
            out_tvalid_o[c]       = ~reset & (path_ch_s == EP_NUM_W'(c)) & beat_v_s;
            out_tlast_o[c]        = ~reset & (path_ch_s == EP_NUM_W'(c)) & beat_last_s;
            out_tdata_o[8*c +: 8] = {8{~reset & (path_ch_s == EP_NUM_W'(c)) & beat_v_s}} & beat_data_s;
        end
    end

`ifdef USB_EP_STATS_EN
    logic        pkt_inc_s;
    logic [15:0] pkt_cnt_r [NUM_EPS];

    // One completed transaction: accepted IN tlast beat, or OUT entering FLUSH.
    always_comb begin
        pkt_inc_s = (in_beat_s & bid_tlast_s)
                  | ((state_r == ST_OUT) & ~tl.blk_out_xfer_i & hit_q_r);
    end

    // Wrapping per-channel packet counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_EPS; c++) pkt_cnt_r[c] <= 16'h0000;
        end else begin
            for (int c = 0; c < NUM_EPS; c++) begin
                if (pkt_inc_s && path_ch_s == EP_NUM_W'(c)) pkt_cnt_r[c] <= pkt_cnt_r[c] + 16'd1;
            end
        end
    end

    // Pack the counters onto the flat output port.
    always_comb begin
        ep_pkt_count_o = {(16*NUM_EPS){1'b0}};
        for (int c = 0; c < NUM_EPS; c++) ep_pkt_count_o[16*c +: 16] = pkt_cnt_r[c];
    end
`endif

endmodule

// File: tb/tb_usb_bulk_ep_mux.sv
// Directed bench for usb_bulk_ep_mux (NUM_EPS=2, MAX_PACKET=64).
// Counter checks are compiled when USB_EP_STATS_EN is defined.
module tb_usb_bulk_ep_mux;

    logic        clock = 1'b0;
    logic        reset;
    logic        configured;
    logic [1:0]  in_has_data, in_tvalid, in_tready, in_tlast, out_ready, out_tvalid, out_tlast;
    logic [15:0] in_tdata, out_tdata;
`ifdef USB_EP_STATS_EN
    logic [31:0] ep_pkt_count;
`endif
    int n_checks = 0;
    int n_errors = 0;

    usb_bulk_ep_mux_if tl_if ();

    usb_bulk_ep_mux #(.NUM_EPS(2), .MAX_PACKET(64), .CW(10)) dut (
        .clock         (clock),
        .reset         (reset),
        .configured_i  (configured),
        .tl            (tl_if.slave),
        .in_has_data_i (in_has_data),
        .in_tvalid_i   (in_tvalid),
        .in_tready_o   (in_tready),
        .in_tlast_i    (in_tlast),
        .in_tdata_i    (in_tdata),
        .out_ready_i   (out_ready),
        .out_tvalid_o  (out_tvalid),
        .out_tlast_o   (out_tlast),
        .out_tdata_o   (out_tdata)
`ifdef USB_EP_STATS_EN
        ,
        .ep_pkt_count_o(ep_pkt_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] ob [3];
        int         len;
        logic       done;

        reset = 1'b1; configured = 1'b1;
        in_has_data = 2'b11; in_tvalid = 2'b00; in_tlast = 2'b00; in_tdata = 16'h0000;
        out_ready = 2'b11;
        tl_if.blk_xfer_endpoint_i = 4'd1; tl_if.blk_in_xfer_i = 1'b0; tl_if.blk_out_xfer_i = 1'b0;
        tl_if.bid_tready_i = 1'b0; tl_if.blk_out_tvalid_i = 1'b0; tl_if.blk_out_tdata_i = 8'h00;
        tick(); tick(); settle();
        check_val("rst_has_data", 32'(tl_if.bid_has_data_o), 32'd0);
        check_val("rst_out_ready", 32'(tl_if.blk_out_ready_o), 32'd0);
        check_val("rst_bid_tvalid", 32'(tl_if.bid_tvalid_o), 32'd0);
        check_val("rst_in_tready", 32'(in_tready), 32'd0);
        check_val("rst_out_tvalid", 32'(out_tvalid), 32'd0);

        // IN to EP2, packet A0..A3
        reset = 1'b0; in_has_data = 2'b10; out_ready = 2'b00; tl_if.blk_xfer_endpoint_i = 4'd2;
        settle();
        check_val("adv_ep2_has_data", 32'(tl_if.bid_has_data_o), 32'd1);
        check_val("adv_ep2_out_ready", 32'(tl_if.blk_out_ready_o), 32'd0);
        tl_if.blk_in_xfer_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            d = 8'hA0 + 8'(i);
            in_tvalid = 2'b11; in_tdata = {d, 8'h5A}; in_tlast = {(i == 3), 1'b1};
            tl_if.bid_tready_i = 1'b1;
            settle();
            check_val("ep2_tvalid", 32'(tl_if.bid_tvalid_o), 32'd1);
            check_val("ep2_tdata", 32'(tl_if.bid_tdata_o), 32'(d));
            check_val("ep2_tlast", 32'(tl_if.bid_tlast_o), 32'(i == 3));
            check_val("ep2_in_tready", 32'(in_tready), 32'h2);
            tick();
        end
        tl_if.blk_in_xfer_i = 1'b0; in_tvalid = 2'b00; in_tlast = 2'b00; tl_if.bid_tready_i = 1'b0;
        tick();

        // unmapped endpoint EP3
        tl_if.blk_xfer_endpoint_i = 4'd3; in_has_data = 2'b11; out_ready = 2'b11;
        settle();
        check_val("ep3_has_data", 32'(tl_if.bid_has_data_o), 32'd0);
        check_val("ep3_out_ready", 32'(tl_if.blk_out_ready_o), 32'd0);
        tl_if.blk_in_xfer_i = 1'b1;
        tick();
        in_tvalid = 2'b11; tl_if.bid_tready_i = 1'b1;
        settle();
        check_val("ep3_tvalid", 32'(tl_if.bid_tvalid_o), 32'd0);
        check_val("ep3_in_tready", 32'(in_tready), 32'd0);
        tl_if.blk_in_xfer_i = 1'b0; in_tvalid = 2'b00; tl_if.bid_tready_i = 1'b0;
        tick();

        // EP1 while unconfigured
        tl_if.blk_xfer_endpoint_i = 4'd1; configured = 1'b0;
        settle();
        check_val("uncfg_has_data", 32'(tl_if.bid_has_data_o), 32'd0);
        check_val("uncfg_out_ready", 32'(tl_if.blk_out_ready_o), 32'd0);
        tl_if.blk_in_xfer_i = 1'b1;
        tick();
        in_tvalid = 2'b11; tl_if.bid_tready_i = 1'b1;
        settle();
        check_val("uncfg_tvalid", 32'(tl_if.bid_tvalid_o), 32'd0);
        tl_if.blk_in_xfer_i = 1'b0; in_tvalid = 2'b00; tl_if.bid_tready_i = 1'b0;
        tick();
        configured = 1'b1;

        // 100-byte stream on channel 0 split at 64
        b = 8'd0;
        for (int t = 0; t < 2; t++) begin
            tl_if.blk_in_xfer_i = 1'b1;
            tick();
            len = 0; done = 1'b0;
            while (!done && len < 100) begin
                in_tvalid = 2'b01; in_tdata = {8'h00, b}; in_tlast = {1'b0, (b == 8'd99)};
                tl_if.bid_tready_i = 1'b1;
                settle();
                check_val("split_tdata", 32'(tl_if.bid_tdata_o), 32'(b));
                done = tl_if.bid_tlast_o;
                len++; b++;
                tick();
            end
            tl_if.blk_in_xfer_i = 1'b0; in_tvalid = 2'b00; in_tlast = 2'b00; tl_if.bid_tready_i = 1'b0;
            tick();
            check_val("split_len", 32'(len), (t == 0) ? 32'd64 : 32'd36);
        end

        // OUT to EP1: 11,22,33
        out_ready = 2'b01;
        settle();
        check_val("out_ep1_ready", 32'(tl_if.blk_out_ready_o), 32'd1);
        ob[0] = 8'h11; ob[1] = 8'h22; ob[2] = 8'h33;
        tl_if.blk_out_xfer_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tl_if.blk_out_tvalid_i = 1'b1; tl_if.blk_out_tdata_i = ob[i];
            settle();
            if (i == 0) begin
                check_val("out_first_tvalid", 32'(out_tvalid), 32'd0);
            end else begin
                check_val("out_tvalid", 32'(out_tvalid), 32'h1);
                check_val("out_tdata", 32'(out_tdata[7:0]), 32'(ob[i-1]));
                check_val("out_tlast", 32'(out_tlast), 32'd0);
            end
            tick();
        end
        tl_if.blk_out_tvalid_i = 1'b0; tl_if.blk_out_xfer_i = 1'b0;
        settle();
        check_val("out_fall_tvalid", 32'(out_tvalid), 32'd0);
        tick();
        check_val("flush_tvalid", 32'(out_tvalid), 32'h1);
        check_val("flush_tlast", 32'(out_tlast), 32'h1);
        check_val("flush_tdata", 32'(out_tdata[7:0]), 32'h33);
        tick();
        check_val("post_flush_tvalid", 32'(out_tvalid), 32'd0);

        // zero-length OUT
        tl_if.blk_out_xfer_i = 1'b1;
        tick();
        tl_if.blk_out_xfer_i = 1'b0;
        settle();
        check_val("zlp_out_tvalid", 32'(out_tvalid), 32'd0);
        tick();
        check_val("zlp_flush_tvalid", 32'(out_tvalid), 32'd0);
        check_val("zlp_flush_tlast", 32'(out_tlast), 32'd0);
        tick();

        // reset in the middle of an OUT to EP2
        tl_if.blk_xfer_endpoint_i = 4'd2;
        tl_if.blk_out_xfer_i = 1'b1;
        tick();
        tl_if.blk_out_tvalid_i = 1'b1; tl_if.blk_out_tdata_i = 8'h44;
        tick();
        tl_if.blk_out_tdata_i = 8'h55;
        settle();
        check_val("rstmid_beat_tvalid", 32'(out_tvalid), 32'h2);
        check_val("rstmid_beat_tdata", 32'(out_tdata[15:8]), 32'h44);
        tick();
        reset = 1'b1; tl_if.blk_out_tvalid_i = 1'b0;
        settle();
        check_val("rstmid_in_rst_tvalid", 32'(out_tvalid), 32'd0);
        check_val("rstmid_in_rst_tlast", 32'(out_tlast), 32'd0);
        tick();
        reset = 1'b0; tl_if.blk_out_xfer_i = 1'b0;
        settle();
        check_val("rstmid_after_tvalid", 32'(out_tvalid), 32'd0);
        tick();
        check_val("rstmid_after2_tlast", 32'(out_tlast), 32'd0);
        check_val("rstmid_after2_tvalid", 32'(out_tvalid), 32'd0);
        check_val("rstmid_bid_tvalid", 32'(tl_if.bid_tvalid_o), 32'd0);

        // next OUT to EP2 routes correctly
        tl_if.blk_out_xfer_i = 1'b1;
        tick();
        tl_if.blk_out_tvalid_i = 1'b1; tl_if.blk_out_tdata_i = 8'h66;
        tick();
        tl_if.blk_out_tdata_i = 8'h77;
        settle();
        check_val("rec_tvalid", 32'(out_tvalid), 32'h2);
        check_val("rec_tdata", 32'(out_tdata[15:8]), 32'h66);
        tick();
        tl_if.blk_out_tvalid_i = 1'b0; tl_if.blk_out_xfer_i = 1'b0;
        tick();
        check_val("rec_flush_tvalid", 32'(out_tvalid), 32'h2);
        check_val("rec_flush_tlast", 32'(out_tlast), 32'h2);
        check_val("rec_flush_tdata", 32'(out_tdata[15:8]), 32'h77);
        tick();

`ifdef USB_EP_STATS_EN
        // 3 IN + 2 OUT (one zero-length) on EP1
        tl_if.blk_xfer_endpoint_i = 4'd1;
        for (int t = 0; t < 3; t++) begin
            tl_if.blk_in_xfer_i = 1'b1; in_tvalid = 2'b01; in_tlast = 2'b01;
            in_tdata = 16'h00C0; tl_if.bid_tready_i = 1'b1;
            tick();
            tick();
            tl_if.blk_in_xfer_i = 1'b0; in_tvalid = 2'b00; in_tlast = 2'b00; tl_if.bid_tready_i = 1'b0;
            tick();
        end
        tl_if.blk_out_xfer_i = 1'b1;
        tick();
        tl_if.blk_out_tvalid_i = 1'b1; tl_if.blk_out_tdata_i = 8'h99;
        tick();
        tl_if.blk_out_tvalid_i = 1'b0; tl_if.blk_out_xfer_i = 1'b0;
        tick();
        tick();
        tl_if.blk_out_xfer_i = 1'b1;
        tick();
        tl_if.blk_out_xfer_i = 1'b0;
        tick();
        tick();
        check_val("stats_ch0", 32'(ep_pkt_count[15:0]), 32'd5);
        check_val("stats_ch1", 32'(ep_pkt_count[31:16]), 32'd1);

        // run channel 0 up to the wrap point with back-to-back tlast beats
        tl_if.blk_in_xfer_i = 1'b1; in_tvalid = 2'b01; in_tlast = 2'b01; tl_if.bid_tready_i = 1'b1;
        tick();
        repeat (65530) @(posedge clock);
        #1;
        in_tvalid = 2'b00;
        settle();
        check_val("stats_ffff", 32'(ep_pkt_count[15:0]), 32'h0000FFFF);
        in_tvalid = 2'b01;
        tick();
        in_tvalid = 2'b00;
        settle();
        check_val("stats_wrap", 32'(ep_pkt_count[15:0]), 32'd0);
        tl_if.blk_in_xfer_i = 1'b0; in_tlast = 2'b00; tl_if.bid_tready_i = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
